sram_like_slave: RTL
====================

// Module: sram_like_slave
// PURPOSE
//  Responder end of the CPU's req/addr_ok/data_ok SRAM-like bus. Accepts requests from the
//  inst-side or data-side master and returns in-order responses after a configurable latency
//  from an internal word-addressed RAM. Used as the memory model behind mycpu_top in exp14+ benches.
// PARAMETERS
//  ADDR_WIDTH   12       word-address bits; RAM depth = 2**ADDR_WIDTH words of 32b
//  LATENCY      2        cycles from accept to data_ok (>=1)
//  OUTSTANDING  4        max accepted-but-unanswered requests (power of 2, >=2)
//  SEED         16'hACE1 LFSR seed (used only with SRAM_RANDOM_DELAY_EN)
// PORTS
//  clk      in   1    clock, all logic on rising edge
//  reset    in   1    synchronous, active-high
//  req      in   1    master request valid
//  wr       in   1    1 = write, 0 = read
//  size     in   2    0:byte 1:half 2:word; recorded, not used for access (wstrb is authoritative)
//  addr     in   32   byte address; RAM index = addr[ADDR_WIDTH+1:2], upper bits ignored (wrap)
//  wstrb    in   4    byte enables for writes
//  wdata    in   32   write data
//  addr_ok  out  1    request accepted this cycle when req && addr_ok
//  data_ok  out  1    one-cycle response pulse, one per accepted request (reads and writes)
//  rdata    out  32   read data, valid only when data_ok for a read; else 32'h0
// BEHAVIOUR
//  - Reset (sync, high): pending queue cleared, addr_ok=0, data_ok=0, rdata=0 in the cycle
//    after the reset edge; addr_ok=1 from the first cycle after reset deasserts. RAM contents kept.
//  - Reset mid-operation: all pending requests dropped, no data_ok for them, pending writes not committed.
//  - addr_ok = !reset && (pending_count < OUTSTANDING); depends on registered count only; no
//    combinational path from req or from this cycle's retirement.
//  - Accept: req && addr_ok -> push {wr,size,index,wstrb,wdata,timer} into in-order queue.
//  - Latency: request accepted in cycle T gets data_ok in cycle T+LATENCY, unless an older
//    response occupies that cycle; then it follows immediately after. Max one data_ok/cycle.
//    Back-to-back accepts give back-to-back data_ok.
//  - Retire: in the data_ok cycle a read drives rdata = RAM[index] (reflects all older writes);
//    a write commits wdata byte lanes with wstrb=1 at that clock edge; rdata=0 for writes.
//  - Read-after-write to same word in queue returns new data (in-order commit guarantees this).
//  - wstrb=4'b0000 write: data_ok still pulses, RAM unchanged.
//  - Simultaneous accept+retire: count unchanged; allowed also when count==OUTSTANDING-1.
//  - Full (count==OUTSTANDING): addr_ok=0; req held by master is accepted the cycle after a retire.
//  - Queue pointers wrap modulo OUTSTANDING; count width $clog2(OUTSTANDING)+1.
//  - data_ok never asserts with an empty queue; rdata returns to 0 the cycle after data_ok.
// CONFIGURATION
//  SRAM_RANDOM_DELAY_EN defined: 16-bit Galois LFSR (taps 16,14,13,11, init SEED, reset to SEED,
//    steps every cycle). addr_ok additionally ANDed with lfsr[0]; each accepted entry gets extra
//    latency lfsr[2:1] (0-3 cycles) sampled at accept. Order and one-response-per-request kept.
//  Not defined: no LFSR; addr_ok/latency strictly as above (deterministic).
// TESTING
//  1 reset held 3 cycles, release -> addr_ok=0 during reset, 1 next cycle; data_ok=0, rdata=0.
//  2 write addr=32'h10 wstrb=4'hF wdata=32'hDEADBEEF at T, read addr=32'h10 at T+1 ->
//    data_ok at T+2 (rdata=0) and T+3 with rdata=32'hDEADBEEF (LATENCY=2).
//  3 write wstrb=4'b0010 wdata=32'h0000AB00 over 32'h11223344, then read -> rdata=32'h1122AB44.
//  4 req held high 8 reads, OUTSTANDING=4, LATENCY=8 -> addr_ok drops after 4 accepts, one new
//    accept per retire; exactly 8 data_ok pulses, data in issue order.
//  5 two reads pending, assert reset for 1 cycle -> no further data_ok; pending write never committed.
//  6 addr=32'h0000_4010 with ADDR_WIDTH=12 -> aliases index 4 (same as addr 32'h10).

Source files
------------

// File: rtl/sram_like_slave.sv
// sram_like_slave: in-order SRAM-like bus responder backed by a word-addressed RAM.
// Define SRAM_RANDOM_DELAY_EN to throttle addr_ok and add 0-3 cycles of LFSR latency per request.
module sram_like_slave #(
    parameter int          ADDR_WIDTH  = 12,
    parameter int          LATENCY     = 2,
    parameter int          OUTSTANDING = 4,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int TW = $clog2(LATENCY + 4);

    logic [31:0]           ram     [2**ADDR_WIDTH];
    logic                  q_wr    [OUTSTANDING];
    logic [1:0]            q_size  [OUTSTANDING];
    logic [ADDR_WIDTH-1:0] q_idx   [OUTSTANDING];
    logic [3:0]            q_wstrb [OUTSTANDING];
    logic [31:0]           q_wdata [OUTSTANDING];
    logic [TW-1:0]         q_timer [OUTSTANDING];
    logic [PW-1:0]         head, tail;
    logic [PW:0]           count;
    logic                  push, pop, gate;
    logic [TW-1:0]         extra;
    logic                  unused_bits;

`ifdef SRAM_RANDOM_DELAY_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        lfsr <= reset ? SEED : ({1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000));
    end
    assign gate  = lfsr[0];
    assign extra = TW'(lfsr[2:1]);
`else
    assign gate  = 1'b1;
    assign extra = '0;
`endif

    // Handshake depends on registered state only, so no req-to-addr_ok path exists.
    always_comb begin
        addr_ok = !reset && (count < (PW+1)'(OUTSTANDING)) && gate;
        data_ok = !reset && (count != '0) && (q_timer[head] == '0);
        push    = req && addr_ok;
        pop     = data_ok;
        rdata   = (data_ok && !q_wr[head]) ? ram[q_idx[head]] : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop) head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    // Every entry counts down each cycle; only the head may retire, which keeps order.
    always_ff @(posedge clk) begin
        for (int i = 0; i < OUTSTANDING; i++)
            if (q_timer[i] != '0) q_timer[i] <= q_timer[i] - TW'(1);
        if (push) begin
            q_wr[tail]    <= wr;
            q_size[tail]  <= size;
            q_idx[tail]   <= addr[ADDR_WIDTH+1:2];
            q_wstrb[tail] <= wstrb;
            q_wdata[tail] <= wdata;
            q_timer[tail] <= TW'(LATENCY - 1) + extra;
        end
    end

    always_ff @(posedge clk) begin
        if (pop && q_wr[head])
            for (int b = 0; b < 4; b++)
                if (q_wstrb[head][b]) ram[q_idx[head]][8*b +: 8] <= q_wdata[head][8*b +: 8];
    end

    assign unused_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0], q_size[head], SEED};
endmodule
